// File: rtl/a_lock_sequencer_pkg.sv
// a_lock_pkg: shared state encoding, keypad command codes and digit-count width for the lock sequencer
package a_lock_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_WAIT_CHK, S_UNLOCK, S_PROG, S_LOCKOUT} state_t;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
  localparam logic [3:0] KEY_PROG = 4'hC;
  localparam int DCNT_W = 3;
endpackage

// File: rtl/a_lock_sequencer_if.sv
// a_lock_sequencer_if: keypad/checker bus; master = keypad+checker side, slave = sequencer (keys, compare handshake, lock status)
interface a_lock_sequencer_if;
  import a_lock_pkg::*;
  logic key_valid;
  logic [3:0] key_code;
  logic check_valid;
  logic check_match;
  logic [15:0] pw_entry;
  logic check_req;
  logic [15:0] stored_pw;
  logic unlock;
  logic lockout;
  logic [2:0] err_cnt;
  logic [DCNT_W-1:0] digit_cnt;
  logic prog_done;
  modport master (
    output key_valid, key_code, check_valid, check_match,
    input pw_entry, check_req, stored_pw, unlock, lockout, err_cnt, digit_cnt, prog_done
  );
  modport slave (
    input key_valid, key_code, check_valid, check_match,
    output pw_entry, check_req, stored_pw, unlock, lockout, err_cnt, digit_cnt, prog_done
  );
endinterface

// File: rtl/a_lock_sequencer_timer.sv
// a_lock_timer: loadable down-counter; clk/reset, load+value reload it, expire flags the last counted cycle
module a_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (load) cnt_q <= value;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign expire = cnt_q == W'(1);
endmodule

// File: rtl/a_lock_sequencer.sv
// a_lock_sequencer: keypad code sequencer; clk/reset plus bus (keys, compare handshake, stored password, lock status)
module a_lock_sequencer
  import a_lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PW = 16'h1234,
  parameter int MAX_ERRORS = 3,
  parameter int UNLOCK_CYCLES = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter int ENTRY_TIMEOUT = 250_000_000,
  parameter int CHECK_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  a_lock_sequencer_if.slave bus
);
  localparam int MAX_UL = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_EC = ENTRY_TIMEOUT > CHECK_TIMEOUT ? ENTRY_TIMEOUT : CHECK_TIMEOUT;
  // +1 so a power-of-two duration still fits
  localparam int TW = $clog2((MAX_UL > MAX_EC ? MAX_UL : MAX_EC) + 1);
  localparam logic [2:0] MAX_E = 3'(MAX_ERRORS);
  state_t state_q, state_d;
  logic [15:0] pw_q, pw_d, spw_q, spw_d;
  logic [DCNT_W-1:0] dc_q, dc_d;
  logic [2:0] err_q, err_d, err_inc;
  logic req_q, req_d, done_q, done_d, unl_q, lck_q;
  logic tmr_load, tmr_exp, key_ok, is_dig, chk_ok, full, push, clr, fail;
  logic [TW-1:0] tmr_val;
  a_lock_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(tmr_load),
    .value(tmr_val),
    .expire(tmr_exp)
  );
  assign key_ok = bus.key_valid && bus.key_code <= KEY_PROG;
  assign is_dig = bus.key_valid && bus.key_code <= 4'd9;
  // a response in the request cycle itself is too early to be ours
  assign chk_ok = bus.check_valid && !req_q;
  assign full = dc_q == DCNT_W'(4);
  assign err_inc = err_q >= MAX_E ? MAX_E : err_q + 3'd1;
  always_comb begin
    state_d = state_q;
    pw_d = pw_q;
    dc_d = dc_q;
    err_d = err_q;
    spw_d = spw_q;
    req_d = 1'b0;
    done_d = 1'b0;
    tmr_load = 1'b0;
    tmr_val = TW'(ENTRY_TIMEOUT);
    push = 1'b0;
    clr = 1'b0;
    fail = 1'b0;
    case (state_q)
      S_IDLE: begin
        push = is_dig;
        tmr_load = is_dig;
        state_d = is_dig ? S_ENTRY : S_IDLE;
      end
      S_ENTRY, S_PROG: begin
        tmr_load = key_ok;
        push = is_dig && !full;
        if (key_ok && bus.key_code == KEY_CLR) begin
          clr = 1'b1;
          state_d = S_IDLE;
        end else if (key_ok && bus.key_code == KEY_ENT) begin
          if (state_q == S_PROG) begin
            if (full) begin
              spw_d = pw_q;
              done_d = 1'b1;
              clr = 1'b1;
              state_d = S_IDLE;
            end
          end else if (full) begin
            req_d = 1'b1;
            tmr_val = TW'(CHECK_TIMEOUT);
            state_d = S_WAIT_CHK;
          end else fail = 1'b1;
        end else if (!key_ok && tmr_exp) begin
          clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_CHK: begin
        if (chk_ok && bus.check_match) begin
          err_d = '0;
          clr = 1'b1;
          tmr_load = 1'b1;
          tmr_val = TW'(UNLOCK_CYCLES);
          state_d = S_UNLOCK;
        end else fail = chk_ok || tmr_exp;
      end
      S_UNLOCK: begin
        if (key_ok && bus.key_code == KEY_CLR) state_d = S_IDLE;
        else if (key_ok && bus.key_code == KEY_PROG) begin
          tmr_load = 1'b1;
          state_d = S_PROG;
        end else if (tmr_exp) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (tmr_exp) begin
          err_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push) begin
      pw_d = {pw_q[11:0], bus.key_code};
      dc_d = dc_q + 1'b1;
    end
    if (clr) begin
      pw_d = '0;
      dc_d = '0;
    end
    if (fail) begin
      err_d = err_inc;
      pw_d = '0;
      dc_d = '0;
      tmr_load = err_inc == MAX_E;
      tmr_val = TW'(LOCKOUT_CYCLES);
      state_d = err_inc == MAX_E ? S_LOCKOUT : S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pw_q <= '0;
      dc_q <= '0;
      err_q <= '0;
      spw_q <= DEFAULT_PW;
      req_q <= 1'b0;
      done_q <= 1'b0;
      unl_q <= 1'b0;
      lck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q <= pw_d;
      dc_q <= dc_d;
      err_q <= err_d;
      spw_q <= spw_d;
      req_q <= req_d;
      done_q <= done_d;
      unl_q <= state_d inside {S_UNLOCK, S_PROG};
      lck_q <= state_d == S_LOCKOUT;
    end
  end
  assign bus.pw_entry = pw_q;
  assign bus.digit_cnt = dc_q;
  assign bus.err_cnt = err_q;
  assign bus.stored_pw = spw_q;
  assign bus.check_req = req_q;
  assign bus.prog_done = done_q;
  assign bus.unlock = unl_q;
  assign bus.lockout = lck_q;
endmodule
